// File: rtl/z80_reg_unit_if.sv
`default_nettype none
// ============================================================================
// z80_reg_unit_if : sequencer control strobes feeding the Z80 register unit
// Rev 1.0
// ============================================================================
interface z80_reg_unit_if;
  logic [1:0] ctl_reg_gp_sel;
  logic [1:0] ctl_reg_gp_hilo;
  logic       ctl_reg_gp_we;
  logic [1:0] ctl_reg_sys_hilo;
  logic       ctl_reg_sys_we_lo;
  logic       ctl_reg_sys_we_hi;
  logic       ctl_reg_sys_we;
  logic       ctl_reg_sel_pc;
  logic       ctl_reg_sel_ir;
  logic       ctl_reg_sel_wz;
  logic       ctl_reg_not_pc;
  logic       ctl_reg_use_sp;
  logic       use_ixiy;
  logic       use_ix;
  logic       ctl_reg_exx;
  logic       ctl_reg_ex_af;
  logic       ctl_reg_ex_de_hl;
  logic       nhold_clk_wait;
  logic       ctl_sw_4d;
  logic       ctl_sw_4u;
  logic       ctl_reg_in_hi;
  logic       ctl_reg_in_lo;
  logic       ctl_reg_out_hi;
  logic       ctl_reg_out_lo;

  modport master (
    output ctl_reg_gp_sel, ctl_reg_gp_hilo, ctl_reg_gp_we, ctl_reg_sys_hilo,
           ctl_reg_sys_we_lo, ctl_reg_sys_we_hi, ctl_reg_sys_we,
           ctl_reg_sel_pc, ctl_reg_sel_ir, ctl_reg_sel_wz, ctl_reg_not_pc,
           ctl_reg_use_sp, use_ixiy, use_ix, ctl_reg_exx, ctl_reg_ex_af,
           ctl_reg_ex_de_hl, nhold_clk_wait, ctl_sw_4d, ctl_sw_4u,
           ctl_reg_in_hi, ctl_reg_in_lo, ctl_reg_out_hi, ctl_reg_out_lo
  );

  modport slave (
    input  ctl_reg_gp_sel, ctl_reg_gp_hilo, ctl_reg_gp_we, ctl_reg_sys_hilo,
           ctl_reg_sys_we_lo, ctl_reg_sys_we_hi, ctl_reg_sys_we,
           ctl_reg_sel_pc, ctl_reg_sel_ir, ctl_reg_sel_wz, ctl_reg_not_pc,
           ctl_reg_use_sp, use_ixiy, use_ix, ctl_reg_exx, ctl_reg_ex_af,
           ctl_reg_ex_de_hl, nhold_clk_wait, ctl_sw_4d, ctl_sw_4u,
           ctl_reg_in_hi, ctl_reg_in_lo, ctl_reg_out_hi, ctl_reg_out_lo
  );
endinterface
`default_nettype wire

// File: rtl/z80_reg_unit.sv
`default_nettype none
// ============================================================================
// z80_reg_unit : Z80 register select decode and storage on four byte buses
// Rev 1.0
// ============================================================================
module z80_reg_unit (
  input  wire logic     clk,
  input  wire logic     nreset,
  z80_reg_unit_if.slave ctl,
  inout  wire [7:0]     db_lo_ds,
  inout  wire [7:0]     db_hi_ds,
  inout  wire [7:0]     db_lo_as,
  inout  wire [7:0]     db_hi_as
);

  localparam logic [3:0] c_AF  = 4'd0;
  localparam logic [3:0] c_BC  = 4'd1;
  localparam logic [3:0] c_AF2 = 4'd4;
  localparam logic [3:0] c_BC2 = 4'd5;
  localparam logic [3:0] c_IX  = 4'd8;
  localparam logic [3:0] c_IY  = 4'd9;
  localparam logic [3:0] c_SP  = 4'd10;

  logic        r_bank_af;
  logic        r_bank_exx;
  logic [1:0]  r_swap_dehl;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_wz;
  logic [15:0] r_rf [0:10];

  logic        w_sel_pc, w_sel_ir, w_sel_wz, w_sel_gp, w_sel_sp, w_sel_sys, w_sel_as;
  logic        w_swap;
  logic [3:0]  w_gp_idx;
  logic [15:0] w_sel_val;
  logic [15:0] w_bus_ds, w_bus_as, w_wr_data;
  logic [1:0]  w_in, w_out, w_sys_we, w_gp_we, w_rf_we;
  logic [1:0]  w_drv_ds, w_drv_as, w_sw_dn, w_sw_up;

  assign w_sel_pc  = ctl.ctl_reg_sel_pc & ~ctl.ctl_reg_not_pc;
  assign w_sel_ir  = ctl.ctl_reg_sel_ir & ~w_sel_pc;
  assign w_sel_wz  = ctl.ctl_reg_sel_wz & ~w_sel_pc & ~w_sel_ir;
  assign w_sel_gp  = ~(w_sel_pc | w_sel_ir | w_sel_wz);
  assign w_sel_sp  = w_sel_gp & (ctl.ctl_reg_gp_sel == 2'b00) & ctl.ctl_reg_use_sp;
  assign w_sel_sys = w_sel_pc | w_sel_ir | w_sel_wz | w_sel_sp;
  assign w_sel_as  = w_sel_pc | w_sel_ir | w_sel_sp;
  assign w_swap    = r_swap_dehl[r_bank_exx];

  // File index {0,bank,1,swap} lands on DE/HL of the active bank; HL uses ~swap.
  always_comb begin
    w_gp_idx = c_AF;
    case (ctl.ctl_reg_gp_sel)
      2'b00:   w_gp_idx = ctl.ctl_reg_use_sp ? c_SP : (r_bank_af ? c_AF2 : c_AF);
      2'b01:   w_gp_idx = r_bank_exx ? c_BC2 : c_BC;
      2'b10:   w_gp_idx = {1'b0, r_bank_exx, 1'b1, w_swap};
      default: w_gp_idx = ctl.use_ixiy ? (ctl.use_ix ? c_IX : c_IY)
                                       : {1'b0, r_bank_exx, 1'b1, ~w_swap};
    endcase
  end

  always_comb begin
    w_sel_val = r_rf[w_gp_idx];
    if (w_sel_pc)      w_sel_val = r_pc;
    else if (w_sel_ir) w_sel_val = r_ir;
    else if (w_sel_wz) w_sel_val = r_wz;
  end

  assign w_bus_ds  = {db_hi_ds, db_lo_ds};
  assign w_bus_as  = {db_hi_as, db_lo_as};
  assign w_wr_data = w_sel_as ? w_bus_as : w_bus_ds;

  assign w_in     = {ctl.ctl_reg_in_hi, ctl.ctl_reg_in_lo};
  assign w_sys_we = {ctl.ctl_reg_sys_we | ctl.ctl_reg_sys_we_hi,
                     ctl.ctl_reg_sys_we | ctl.ctl_reg_sys_we_lo}
                    & w_in & ctl.ctl_reg_sys_hilo & {2{w_sel_sys}};
  assign w_gp_we  = {2{ctl.ctl_reg_gp_we & w_sel_gp & ~w_sel_sp}} & w_in & ctl.ctl_reg_gp_hilo;
  assign w_rf_we  = (w_gp_we | (w_sys_we & {2{w_sel_sp}})) & {2{ctl.nhold_clk_wait}};

  always_ff @(negedge clk or negedge nreset) begin
    if (!nreset) begin
      r_bank_af   <= 1'b0;
      r_bank_exx  <= 1'b0;
      r_swap_dehl <= 2'b00;
      r_pc        <= 16'h0000;
      r_ir        <= 16'h0000;
      r_wz        <= 16'h0000;
    end else if (ctl.nhold_clk_wait) begin
      if (ctl.ctl_reg_exx)      r_bank_exx <= ~r_bank_exx;
      if (ctl.ctl_reg_ex_af)    r_bank_af  <= ~r_bank_af;
      if (ctl.ctl_reg_ex_de_hl) r_swap_dehl[r_bank_exx] <= ~r_swap_dehl[r_bank_exx];
      if (w_sys_we[0]) begin
        if (w_sel_pc) r_pc[7:0] <= w_wr_data[7:0];
        if (w_sel_ir) r_ir[7:0] <= w_wr_data[7:0];
        if (w_sel_wz) r_wz[7:0] <= w_wr_data[7:0];
      end
      if (w_sys_we[1]) begin
        if (w_sel_pc) r_pc[15:8] <= w_wr_data[15:8];
        if (w_sel_ir) r_ir[15:8] <= w_wr_data[15:8];
        if (w_sel_wz) r_wz[15:8] <= w_wr_data[15:8];
      end
    end
  end

  // The general file keeps its content through reset.
  always_ff @(negedge clk) begin
    if (w_rf_we[0]) r_rf[w_gp_idx][7:0]  <= w_wr_data[7:0];
    if (w_rf_we[1]) r_rf[w_gp_idx][15:8] <= w_wr_data[15:8];
  end

  // A byte being written is never driven; a register drive blocks the switch onto that bus.
  assign w_out    = {ctl.ctl_reg_out_hi, ctl.ctl_reg_out_lo} & ~w_in;
  assign w_drv_ds = w_out & {2{~w_sel_as}};
  assign w_drv_as = w_out & {2{w_sel_as}};
  assign w_sw_dn  = {2{ctl.ctl_sw_4d}} & ctl.ctl_reg_sys_hilo & ~w_drv_as;
  assign w_sw_up  = {2{ctl.ctl_sw_4u & ~ctl.ctl_sw_4d}} & ~w_drv_ds;

  assign db_lo_ds = w_drv_ds[0] ? w_sel_val[7:0]  : (w_sw_up[0] ? db_lo_as : 8'hzz);
  assign db_hi_ds = w_drv_ds[1] ? w_sel_val[15:8] : (w_sw_up[1] ? db_hi_as : 8'hzz);
  assign db_lo_as = w_drv_as[0] ? w_sel_val[7:0]  : (w_sw_dn[0] ? db_lo_ds : 8'hzz);
  assign db_hi_as = w_drv_as[1] ? w_sel_val[15:8] : (w_sw_dn[1] ? db_hi_ds : 8'hzz);

endmodule
`default_nettype wire

// File: tb/tb_z80_reg_unit.sv
`default_nettype none
// ============================================================================
// tb_z80_reg_unit : directed vectors for the Z80 register unit
// Rev 1.0
// ============================================================================
module tb_z80_reg_unit;

  typedef struct packed {
    logic        pc;
    logic        ir;
    logic        wz;
    logic        npc;
    logic [1:0]  sel;
    logic        sp;
    logic        ixiy;
    logic        ix;
    logic [15:0] exp;
  } vec_t;

  logic        clk;
  logic        nreset;
  logic        r_tb_en;
  logic [15:0] r_tb_ds;
  int          n_pass;
  int          n_tot;
  vec_t        vecs [11];

  wire [7:0] db_lo_ds, db_hi_ds, db_lo_as, db_hi_as;

  assign db_lo_ds = r_tb_en ? r_tb_ds[7:0]  : 8'hzz;
  assign db_hi_ds = r_tb_en ? r_tb_ds[15:8] : 8'hzz;

  z80_reg_unit_if cif ();

  z80_reg_unit dut (
    .clk      (clk),
    .nreset   (nreset),
    .ctl      (cif),
    .db_lo_ds (db_lo_ds),
    .db_hi_ds (db_hi_ds),
    .db_lo_as (db_lo_as),
    .db_hi_as (db_hi_as)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    cif.ctl_reg_gp_sel    = 2'b00;
    cif.ctl_reg_gp_hilo   = 2'b00;
    cif.ctl_reg_gp_we     = 1'b0;
    cif.ctl_reg_sys_hilo  = 2'b00;
    cif.ctl_reg_sys_we_lo = 1'b0;
    cif.ctl_reg_sys_we_hi = 1'b0;
    cif.ctl_reg_sys_we    = 1'b0;
    cif.ctl_reg_sel_pc    = 1'b0;
    cif.ctl_reg_sel_ir    = 1'b0;
    cif.ctl_reg_sel_wz    = 1'b0;
    cif.ctl_reg_not_pc    = 1'b0;
    cif.ctl_reg_use_sp    = 1'b0;
    cif.use_ixiy          = 1'b0;
    cif.use_ix            = 1'b0;
    cif.ctl_reg_exx       = 1'b0;
    cif.ctl_reg_ex_af     = 1'b0;
    cif.ctl_reg_ex_de_hl  = 1'b0;
    cif.ctl_sw_4d         = 1'b0;
    cif.ctl_sw_4u         = 1'b0;
    cif.ctl_reg_in_hi     = 1'b0;
    cif.ctl_reg_in_lo     = 1'b0;
    cif.ctl_reg_out_hi    = 1'b0;
    cif.ctl_reg_out_lo    = 1'b0;
    r_tb_en               = 1'b0;
    r_tb_ds               = 16'h0000;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic wr_gp(input logic [1:0] sel, input logic ixiy, input logic ix,
                       input logic [1:0] hilo, input logic [15:0] val);
    clr();
    cif.ctl_reg_gp_sel  = sel;
    cif.use_ixiy        = ixiy;
    cif.use_ix          = ix;
    cif.ctl_reg_gp_hilo = hilo;
    cif.ctl_reg_gp_we   = 1'b1;
    cif.ctl_reg_in_hi   = 1'b1;
    cif.ctl_reg_in_lo   = 1'b1;
    r_tb_en = 1'b1;
    r_tb_ds = val;
    tick();
    clr();
  endtask

  task automatic wr_sys(input logic pc, input logic ir, input logic wz, input logic sp,
                        input logic we, input logic we_hi, input logic we_lo,
                        input logic [15:0] val);
    clr();
    cif.ctl_reg_sel_pc    = pc;
    cif.ctl_reg_sel_ir    = ir;
    cif.ctl_reg_sel_wz    = wz;
    cif.ctl_reg_use_sp    = sp;
    cif.ctl_reg_sys_hilo  = 2'b11;
    cif.ctl_reg_sys_we    = we;
    cif.ctl_reg_sys_we_hi = we_hi;
    cif.ctl_reg_sys_we_lo = we_lo;
    cif.ctl_reg_in_hi     = 1'b1;
    cif.ctl_reg_in_lo     = 1'b1;
    cif.ctl_sw_4d         = 1'b1;
    r_tb_en = 1'b1;
    r_tb_ds = val;
    tick();
    clr();
  endtask

  task automatic pulse(input logic exx, input logic exaf, input logic exdehl);
    clr();
    cif.ctl_reg_exx      = exx;
    cif.ctl_reg_ex_af    = exaf;
    cif.ctl_reg_ex_de_hl = exdehl;
    tick();
    clr();
  endtask

  task automatic rd(input string nm, input logic pc, input logic ir, input logic wz,
                    input logic npc, input logic [1:0] sel, input logic sp,
                    input logic ixiy, input logic ix, input logic [15:0] exp);
    clr();
    cif.ctl_reg_sel_pc = pc;
    cif.ctl_reg_sel_ir = ir;
    cif.ctl_reg_sel_wz = wz;
    cif.ctl_reg_not_pc = npc;
    cif.ctl_reg_gp_sel = sel;
    cif.ctl_reg_use_sp = sp;
    cif.use_ixiy       = ixiy;
    cif.use_ix         = ix;
    cif.ctl_reg_out_hi = 1'b1;
    cif.ctl_reg_out_lo = 1'b1;
    cif.ctl_sw_4u      = 1'b1;
    @(posedge clk);
    #2;
    chk(nm, {db_hi_ds, db_lo_ds}, exp);
    clr();
  endtask

  task automatic rd_gp(input string nm, input logic [1:0] sel, input logic [15:0] exp);
    rd(nm, 1'b0, 1'b0, 1'b0, 1'b0, sel, 1'b0, 1'b0, 1'b0, exp);
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    //             pc    ir    wz    npc   sel    sp    ixiy  ix    exp
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h8141};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h8242};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h8343};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 16'h1357};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'hAA55};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 16'hAB56};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 16'hAC57};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 16'hAD58};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 16'h5A5A};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 16'hA5A5};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 16'hAB56};

    clr();
    cif.nhold_clk_wait = 1'b1;
    nreset = 1'b0;
    tick();
    tick();
    nreset = 1'b1;
    tick();

    rd("reset_pc", 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000);
    rd("reset_ir", 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000);
    rd("reset_wz", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000);

    wr_sys(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8141);
    wr_sys(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8242);
    wr_sys(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8343);
    wr_sys(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1357);
    wr_gp(2'b00, 1'b0, 1'b0, 2'b11, 16'hAA55);
    wr_gp(2'b01, 1'b0, 1'b0, 2'b11, 16'hAB56);
    wr_gp(2'b10, 1'b0, 1'b0, 2'b11, 16'hAC57);
    wr_gp(2'b11, 1'b0, 1'b0, 2'b11, 16'hAD58);
    wr_gp(2'b11, 1'b1, 1'b1, 2'b11, 16'h5A5A);
    wr_gp(2'b11, 1'b1, 1'b0, 2'b11, 16'hA5A5);

    for (int i = 0; i < 11; i++)
      rd($sformatf("vec[%0d]", i), vecs[i].pc, vecs[i].ir, vecs[i].wz, vecs[i].npc,
         vecs[i].sel, vecs[i].sp, vecs[i].ixiy, vecs[i].ix, vecs[i].exp);

    // Byte enables: IY high byte only, WZ low byte only.
    wr_gp(2'b11, 1'b1, 1'b0, 2'b10, 16'h77FF);
    rd("iy_hi_only", 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 16'h77A5);
    wr_sys(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00CC);
    rd("wz_lo_only", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h81CC);

    pulse(1'b1, 1'b0, 1'b0);
    wr_gp(2'b01, 1'b0, 1'b0, 2'b11, 16'h1234);
    pulse(1'b1, 1'b0, 1'b0);
    rd_gp("exx_bc", 2'b01, 16'hAB56);
    pulse(1'b1, 1'b0, 1'b0);
    rd_gp("exx_bc2", 2'b01, 16'h1234);
    pulse(1'b1, 1'b0, 1'b0);

    pulse(1'b0, 1'b1, 1'b0);
    wr_gp(2'b00, 1'b0, 1'b0, 2'b11, 16'hBEEF);
    rd_gp("exaf_af2", 2'b00, 16'hBEEF);
    pulse(1'b0, 1'b1, 1'b0);
    rd_gp("exaf_af", 2'b00, 16'hAA55);

    pulse(1'b0, 1'b0, 1'b1);
    rd_gp("swap_de", 2'b10, 16'hAD58);
    rd_gp("swap_hl", 2'b11, 16'hAC57);
    wr_gp(2'b10, 1'b0, 1'b0, 2'b11, 16'h1111);
    pulse(1'b0, 1'b0, 1'b1);
    rd_gp("unswap_hl", 2'b11, 16'h1111);
    rd_gp("unswap_de", 2'b10, 16'hAC57);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    wr_gp(2'b10, 1'b0, 1'b0, 2'b11, 16'h2222);
    wr_gp(2'b11, 1'b0, 1'b0, 2'b11, 16'h3333);
    rd_gp("bank1_de", 2'b10, 16'h2222);
    pulse(1'b1, 1'b0, 1'b0);
    rd_gp("bank0_de_swapped", 2'b10, 16'h1111);

    // WAIT hold: write and every exchange strobe at once must be ignored.
    clr();
    cif.nhold_clk_wait   = 1'b0;
    cif.ctl_reg_gp_sel   = 2'b01;
    cif.ctl_reg_gp_hilo  = 2'b11;
    cif.ctl_reg_gp_we    = 1'b1;
    cif.ctl_reg_in_hi    = 1'b1;
    cif.ctl_reg_in_lo    = 1'b1;
    cif.ctl_reg_exx      = 1'b1;
    cif.ctl_reg_ex_af    = 1'b1;
    cif.ctl_reg_ex_de_hl = 1'b1;
    r_tb_en = 1'b1;
    r_tb_ds = 16'hFFFF;
    tick();
    clr();
    cif.nhold_clk_wait = 1'b1;
    rd_gp("hold_bc", 2'b01, 16'hAB56);
    rd_gp("hold_de", 2'b10, 16'h1111);
    rd_gp("hold_af", 2'b00, 16'hAA55);

    pulse(1'b0, 1'b1, 1'b0);
    #2;
    nreset = 1'b0;
    rd("rst_pc", 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000);
    nreset = 1'b1;
    tick();
    rd_gp("rst_af_bank", 2'b00, 16'hAA55);
    rd_gp("rst_de_swap", 2'b10, 16'hAC57);
    rd("rst_wz", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000);
    rd("rst_sp_kept", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 16'h1357);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
